misex2_cmd_sequencer: RTL and testbench

- Downstream stage of the misex2 decode PLA.
- Accepts the PLA's 18 decoded output lines as one vector per transaction and buffers vectors in a small FIFO.
- Serialises each asserted line into a separate 5-bit command code on a valid/ready output port, lowest index first.
- Keeps issued-command and dropped-vector counters for debug.

---
 rtl/misex2_cmd_sequencer.sv | 157 +++++++++++++++
 tb/tb_misex2_cmd_sequencer.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/misex2_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// misex2_cmd_sequencer
//
// Takes the 18 decoded lines of the misex2 PLA as one vector per transaction,
// queues vectors in a small FIFO, and serialises each asserted line into its
// own 5-bit command code (lowest index first) on a valid/ready port.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   dec_in      decoded vector, bit i = PLA output line i
//   in_valid    dec_in is valid
//   in_ready    FIFO can accept a vector (not full)
//   out_valid   a command is presented
//   out_code    index (0..17) of the line being issued
//   out_last    final command of the current vector
//   out_ready   consumer accepts the command
//   busy        work register occupied or FIFO non-empty
//   fifo_level  number of vectors stored in the FIFO
//   cmd_cnt     commands issued (wraps)
//   drop_cnt    all-zero vectors discarded (saturates at 255)
// ---------------------------------------------------------------------------
module misex2_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [17:0]              dec_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [4:0]               out_code,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         cmd_cnt,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [17:0]       mem [DEPTH];
    logic [PW-1:0]     wptr_reg, wptr_next;
    logic [PW-1:0]     rptr_reg, rptr_next;
    logic [PW-1:0]     level_reg;
    logic [17:0]       wr_reg, wr_next;
    logic [CNT_W-1:0]  cmd_cnt_reg, cmd_cnt_next;
    logic [7:0]        drop_cnt_reg, drop_cnt_next;

    logic              empty, full, push, pop;
    logic [17:0]       head;
    logic [4:0]        low_idx;
    logic              one_bit;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wptr_reg == rptr_reg);
    assign full  = (wptr_reg[AW] != rptr_reg[AW]) &&
                   (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);

    // No bypass: a full FIFO refuses a push even while it is being popped.
    assign push  = in_valid && !full;
    assign pop   = (state_reg == IDLE) && !empty;
    assign head  = mem[rptr_reg[AW-1:0]];

    assign wptr_next = wptr_reg + PW'(push);
    assign rptr_next = rptr_reg + PW'(pop);

    // Vector storage carries no reset; only the pointers define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_reg[AW-1:0]] <= dec_in;
        end
    end

    // Lowest set bit of the work register.
    always_comb begin
        low_idx = 5'd0;
        for (int i = 17; i >= 0; i--) begin
            if (wr_reg[i]) begin
                low_idx = 5'(i);
            end
        end
    end

    // Exactly one bit left (wr is never zero while issuing).
    assign one_bit = ((wr_reg & (wr_reg - 18'd1)) == 18'd0);

    always_comb begin
        state_next    = state_reg;
        wr_next       = wr_reg;
        cmd_cnt_next  = cmd_cnt_reg;
        drop_cnt_next = drop_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (pop) begin
                    wr_next = head;
                    if (head != 18'd0) begin
                        state_next = ISSUE;
                    end else if (drop_cnt_reg != 8'hFF) begin
                        drop_cnt_next = drop_cnt_reg + 8'd1;
                    end
                end
            end
            ISSUE: begin
                if (out_ready) begin
                    // x & (x-1) clears the lowest set bit, i.e. the one just issued.
                    wr_next      = wr_reg & (wr_reg - 18'd1);
                    cmd_cnt_next = cmd_cnt_reg + 1'b1;
                    if (one_bit) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            level_reg    <= '0;
            wr_reg       <= '0;
            cmd_cnt_reg  <= '0;
            drop_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wptr_reg     <= wptr_next;
            rptr_reg     <= rptr_next;
            level_reg    <= wptr_next - rptr_next;
            wr_reg       <= wr_next;
            cmd_cnt_reg  <= cmd_cnt_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    // All command outputs derive from registers only; out_ready never feeds them.
    assign out_valid  = (state_reg == ISSUE);
    assign out_code   = (state_reg == ISSUE) ? low_idx : 5'd0;
    assign out_last   = (state_reg == ISSUE) && one_bit;
    assign in_ready   = !full;
    assign busy       = (state_reg == ISSUE) || !empty;
    assign fifo_level = level_reg;
    assign cmd_cnt    = cmd_cnt_reg;
    assign drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_misex2_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_misex2_cmd_sequencer
//
// Directed, table-driven bench for misex2_cmd_sequencer. A main instance
// (DEPTH=4, CNT_W=16) covers latency, serialisation, FIFO full behaviour,
// backpressure, drop saturation and mid-vector reset; a small instance
// (DEPTH=2, CNT_W=4) covers the cmd_cnt wrap.
// ---------------------------------------------------------------------------
module tb_misex2_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [17:0]       dec_in = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              out_valid;
    logic [4:0]        out_code;
    logic              out_last;
    logic              out_ready = 1'b0;
    logic              busy;
    logic [LW-1:0]     fifo_level;
    logic [CNT_W-1:0]  cmd_cnt;
    logic [7:0]        drop_cnt;

    // Small instance for the counter wrap.
    logic [17:0]       s_dec = '0;
    logic              s_in_valid = 1'b0;
    logic              s_in_ready;
    logic              s_out_valid;
    logic [4:0]        s_out_code;
    logic              s_out_last;
    logic              s_out_ready = 1'b1;
    logic              s_busy;
    logic [1:0]        s_fifo_level;
    logic [3:0]        s_cmd_cnt;
    logic [7:0]        s_drop_cnt;

    misex2_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dec_in     (dec_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_code   (out_code),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy),
        .fifo_level (fifo_level),
        .cmd_cnt    (cmd_cnt),
        .drop_cnt   (drop_cnt)
    );

    misex2_cmd_sequencer #(.DEPTH(2), .CNT_W(4)) u_dut_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .dec_in     (s_dec),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .out_valid  (s_out_valid),
        .out_code   (s_out_code),
        .out_last   (s_out_last),
        .out_ready  (s_out_ready),
        .busy       (s_busy),
        .fifo_level (s_fifo_level),
        .cmd_cnt    (s_cmd_cnt),
        .drop_cnt   (s_drop_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [4:0] code;
        logic       last;
    } hs_t;
    hs_t hs_q[$];

    bit rnd_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Handshake collector and stall-stability checker, sampled mid-cycle.
    logic       prev_stall = 1'b0;
    logic [4:0] prev_code  = '0;
    logic       prev_last  = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_code", 32'(out_code), 32'(prev_code));
                check("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && out_ready) begin
                hs_q.push_back('{code: out_code, last: out_last});
            end
            prev_stall = out_valid && !out_ready;
            prev_code  = out_code;
            prev_last  = out_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push(input logic [17:0] v);
        dec_in   = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            tick();
        end
    endtask

    typedef struct {
        logic [17:0] vec;
        int          n;
        int          first;
        int          last;
        int          drop;
    } vec_t;
    vec_t tbl [7];

    int exp_cmd  = 0;
    int exp_drop = 0;

    initial begin
        logic [4:0] exp_codes[$];
        logic [4:0] full_codes [8];
        logic       full_lasts [8];

        tbl[0] = '{18'h00005,  2,  0,  2, 0};
        tbl[1] = '{18'h00000,  0,  0,  0, 1};
        tbl[2] = '{18'h20000,  1, 17, 17, 0};
        tbl[3] = '{18'h3FFFF, 18,  0, 17, 0};
        tbl[4] = '{18'h00800,  1, 11, 11, 0};
        tbl[5] = '{18'h10010,  2,  4, 16, 0};
        tbl[6] = '{18'h0AAAA,  8,  1, 15, 0};

        full_codes = '{5'd0, 5'd1, 5'd2, 5'd8, 5'd0, 5'd17, 5'd4, 5'd5};
        full_lasts = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        // ---------------- Reset state; pushes ignored in reset ----------------
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_code", 32'(out_code), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_cmd_cnt", 32'(cmd_cnt), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        dec_in   = 18'h00001;
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        check("rst_no_push_level", 32'(fifo_level), 32'd0);
        #2;
        rst_n = 1'b1;

        // ---------------- Latency: push 0x00005 with out_ready=1 ----------------
        out_ready = 1'b1;
        tick();
        hs_q.delete();
        push(18'h00005);
        check("lat_n1_valid", 32'(out_valid), 32'd0);
        check("lat_n1_busy", 32'(busy), 32'd1);
        check("lat_n1_level", 32'(fifo_level), 32'd1);
        tick();
        check("lat_n2_valid", 32'(out_valid), 32'd1);
        check("lat_n2_code", 32'(out_code), 32'd0);
        check("lat_n2_last", 32'(out_last), 32'd0);
        tick();
        check("lat_n3_valid", 32'(out_valid), 32'd1);
        check("lat_n3_code", 32'(out_code), 32'd2);
        check("lat_n3_last", 32'(out_last), 32'd1);
        tick();
        check("lat_n4_valid", 32'(out_valid), 32'd0);
        check("lat_busy_after", 32'(busy), 32'd0);
        check("lat_cmd_cnt", 32'(cmd_cnt), 32'd2);
        check("lat_level", 32'(fifo_level), 32'd0);
        exp_cmd = 2;

        // ---------------- Counter wrap on the CNT_W=4 instance ----------------
        s_dec = 18'h07FFF;
        s_in_valid = 1'b1;
        tick();
        s_in_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!s_busy) break;
            tick();
        end
        check("wrap_pre_cnt", 32'(s_cmd_cnt), 32'd15);
        s_dec = 18'h00001;
        s_in_valid = 1'b1;
        tick();
        s_in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!s_busy) break;
            tick();
        end
        check("wrap_cnt_zero", 32'(s_cmd_cnt), 32'd0);
        check("wrap_busy", 32'(s_busy), 32'd0);

        // ---------------- Table-driven single vectors ----------------
        for (int t = 0; t < 7; t++) begin
            hs_q.delete();
            exp_codes.delete();
            for (int b = 0; b < 18; b++) begin
                if (tbl[t].vec[b]) exp_codes.push_back(5'(b));
            end
            push(tbl[t].vec);
            wait_idle(60);
            tick();
            exp_cmd  += tbl[t].n;
            exp_drop += tbl[t].drop;
            check($sformatf("tbl%0d_idle", t), 32'(busy), 32'd0);
            check($sformatf("tbl%0d_ncmd", t), 32'(hs_q.size()), 32'(tbl[t].n));
            if (hs_q.size() > 0) begin
                check($sformatf("tbl%0d_first", t), 32'(hs_q[0].code), 32'(tbl[t].first));
                check($sformatf("tbl%0d_lastcode", t), 32'(hs_q[hs_q.size()-1].code), 32'(tbl[t].last));
            end
            for (int i = 0; i < hs_q.size() && i < exp_codes.size(); i++) begin
                check($sformatf("tbl%0d_code%0d", t, i), 32'(hs_q[i].code), 32'(exp_codes[i]));
                check($sformatf("tbl%0d_lastflag%0d", t, i), 32'(hs_q[i].last), 32'(i == exp_codes.size() - 1));
            end
            check($sformatf("tbl%0d_cmd_cnt", t), 32'(cmd_cnt), 32'(exp_cmd));
            check($sformatf("tbl%0d_drop_cnt", t), 32'(drop_cnt), 32'(exp_drop));
            $display("[TB] vector 0x%05h: %0d commands, cmd_cnt=%0d drop_cnt=%0d",
                     tbl[t].vec, hs_q.size(), cmd_cnt, drop_cnt);
        end

        // ---------------- FIFO fill with out_ready=0, refusal when full ----------------
        out_ready = 1'b0;
        check("full_rdy0", 32'(in_ready), 32'd1);
        push(18'h00001);
        check("full_rdy1", 32'(in_ready), 32'd1);
        push(18'h00006);
        check("full_rdy2", 32'(in_ready), 32'd1);
        push(18'h00100);
        check("full_rdy3", 32'(in_ready), 32'd1);
        push(18'h20001);
        check("full_level3", 32'(fifo_level), 32'd3);
        check("full_rdy4", 32'(in_ready), 32'd1);
        check("full_head_valid", 32'(out_valid), 32'd1);
        check("full_head_code", 32'(out_code), 32'd0);
        push(18'h00030);
        check("full_level4", 32'(fifo_level), 32'd4);
        check("full_rdy_low", 32'(in_ready), 32'd0);
        dec_in   = 18'h00003;
        in_valid = 1'b1;
        tick();
        tick();
        check("full_refuse_level", 32'(fifo_level), 32'd4);
        hs_q.delete();
        out_ready = 1'b1;
        tick();
        // Handshake of the single-bit head done; this cycle pops while still full.
        check("full_pop_cycle_valid", 32'(out_valid), 32'd0);
        check("full_pop_cycle_rdy", 32'(in_ready), 32'd0);
        tick();
        in_valid = 1'b0;
        check("full_no_bypass_level", 32'(fifo_level), 32'd3);
        check("full_next_code", 32'(out_code), 32'd1);
        wait_idle(100);
        tick();
        check("full_drain_idle", 32'(busy), 32'd0);
        check("full_drain_n", 32'(hs_q.size()), 32'd8);
        for (int i = 0; i < hs_q.size() && i < 8; i++) begin
            check($sformatf("full_code%0d", i), 32'(hs_q[i].code), 32'(full_codes[i]));
            check($sformatf("full_last%0d", i), 32'(hs_q[i].last), 32'(full_lasts[i]));
        end
        exp_cmd += 8;
        check("full_cmd_cnt", 32'(cmd_cnt), 32'(exp_cmd));
        $display("[TB] full-FIFO drain: %0d commands, cmd_cnt=%0d", hs_q.size(), cmd_cnt);

        // ---------------- Random backpressure on 0x3FFFF ----------------
        hs_q.delete();
        rnd_ready = 1'b1;
        push(18'h3FFFF);
        for (int i = 0; i < 400; i++) begin
            if (hs_q.size() >= 18 && !busy) break;
            tick();
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_idle", 32'(busy), 32'd0);
        check("bp_n", 32'(hs_q.size()), 32'd18);
        for (int i = 0; i < hs_q.size() && i < 18; i++) begin
            check($sformatf("bp_code%0d", i), 32'(hs_q[i].code), 32'(i));
            check($sformatf("bp_last%0d", i), 32'(hs_q[i].last), 32'(i == 17));
        end
        exp_cmd += 18;
        check("bp_cmd_cnt", 32'(cmd_cnt), 32'(exp_cmd));
        $display("[TB] backpressure 0x3FFFF: %0d commands, cmd_cnt=%0d", hs_q.size(), cmd_cnt);

        // ---------------- drop_cnt saturation ----------------
        dec_in   = 18'h00000;
        in_valid = 1'b1;
        for (int i = 0; i < 260; i++) tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("drop_sat", 32'(drop_cnt), 32'd255);
        check("drop_cmd_unchanged", 32'(cmd_cnt), 32'(exp_cmd));
        check("drop_idle", 32'(busy), 32'd0);
        $display("[TB] 260 zero vectors: drop_cnt=%0d", drop_cnt);

        // ---------------- Reset mid-vector ----------------
        out_ready = 1'b0;
        push(18'h00003);
        push(18'h00004);
        push(18'h00008);
        check("mrst_pre_valid", 32'(out_valid), 32'd1);
        check("mrst_pre_level", 32'(fifo_level), 32'd2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_level", 32'(fifo_level), 32'd0);
        check("mrst_cmd_cnt", 32'(cmd_cnt), 32'd0);
        check("mrst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        dec_in   = 18'h00005;
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        hs_q.delete();
        for (int i = 0; i < 10; i++) tick();
        check("mrst_no_stale_cmds", 32'(hs_q.size()), 32'd0);
        check("mrst_post_valid", 32'(out_valid), 32'd0);
        check("mrst_post_level", 32'(fifo_level), 32'd0);
        check("mrst_post_cmd_cnt", 32'(cmd_cnt), 32'd0);
        $display("[TB] mid-vector reset: %0d stale commands, level=%0d", hs_q.size(), fifo_level);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
